// File: rtl/updown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updown_ctrl
// Brief    : Synchronizes and debounces two push-buttons and turns accepted
//            presses into single-cycle step pulses with a direction flag.
//            Optional auto-repeat: define UPDOWN_CTRL_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================

module updown_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic direction
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_up   = 2'd1;
  localparam logic [1:0] c_st_down = 2'd2;
  localparam logic [1:0] c_st_lock = 2'd3;

  localparam logic [7:0] c_deb_limit = 8'(DEBOUNCE_CYCLES);

  logic [1:0] w_btn_raw;
  logic [1:0] w_btn_level;
  logic       w_up;
  logic       w_dn;
  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       w_fire;
  logic       w_fire_dir;
  logic       w_rpt_due;
  logic       r_enable;
  logic       r_direction;

  assign w_btn_raw = {btn_down, btn_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic       r_sync_meta;
    logic       r_sync;
    logic       r_level;
    logic [7:0] r_stable_cnt;

    // The level flips on the edge that observes a full count while still differing.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync_meta  <= 1'b0;
        r_sync       <= 1'b0;
        r_level      <= 1'b0;
        r_stable_cnt <= 8'd0;
      end else begin
        r_sync_meta <= w_btn_raw[gi];
        r_sync      <= r_sync_meta;
        if (r_sync == r_level) begin
          r_stable_cnt <= 8'd0;
        end else if (r_stable_cnt == c_deb_limit) begin
          r_level      <= ~r_level;
          r_stable_cnt <= 8'd0;
        end else begin
          r_stable_cnt <= r_stable_cnt + 8'd1;
        end
      end
    end

    assign w_btn_level[gi] = r_level;
  end

  assign w_up = w_btn_level[0];
  assign w_dn = w_btn_level[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_enable    <= 1'b0;
      r_direction <= 1'b1;
    end else begin
      r_state  <= w_next_state;
      r_enable <= w_fire;
      if (w_fire) begin
        r_direction <= w_fire_dir;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_up && w_dn)  w_next_state = c_st_lock;
        else if (w_up)     w_next_state = c_st_up;
        else if (w_dn)     w_next_state = c_st_down;
      end
      c_st_up: begin
        if (w_dn)          w_next_state = c_st_lock;
        else if (!w_up)    w_next_state = c_st_idle;
      end
      c_st_down: begin
        if (w_up)          w_next_state = c_st_lock;
        else if (!w_dn)    w_next_state = c_st_idle;
      end
      c_st_lock: begin
        if (!w_up && !w_dn) w_next_state = c_st_idle;
      end
      default:             w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    w_fire     = 1'b0;
    w_fire_dir = r_direction;
    if (r_state == c_st_idle && w_next_state == c_st_up) begin
      w_fire     = 1'b1;
      w_fire_dir = 1'b1;
    end else if (r_state == c_st_idle && w_next_state == c_st_down) begin
      w_fire     = 1'b1;
      w_fire_dir = 1'b0;
    end else if (w_rpt_due && !r_enable) begin
      w_fire     = 1'b1;
      w_fire_dir = (r_state == c_st_up);
    end
  end

`ifdef UPDOWN_CTRL_AUTO_REPEAT_EN
  localparam logic [15:0] c_rpt_first = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] c_rpt_next  = 16'(REPEAT_PERIOD - 1);

  logic [15:0] r_rpt_cnt;
  logic        r_rpt_armed;
  logic        w_rpt_hold;

  // Repeat runs only while the press state is kept across this edge.
  assign w_rpt_hold = ((r_state == c_st_up) || (r_state == c_st_down)) &&
                      (w_next_state == r_state);
  assign w_rpt_due  = w_rpt_hold &&
                      (r_rpt_cnt == (r_rpt_armed ? c_rpt_next : c_rpt_first));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt_cnt   <= 16'd0;
      r_rpt_armed <= 1'b0;
    end else if (!w_rpt_hold) begin
      r_rpt_cnt   <= 16'd0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_due) begin
      r_rpt_cnt   <= 16'd0;
      r_rpt_armed <= 1'b1;
    end else begin
      r_rpt_cnt   <= r_rpt_cnt + 16'd1;
    end
  end
`else
  assign w_rpt_due = 1'b0;
`endif

  assign enable    = r_enable;
  assign direction = r_direction;

endmodule

`default_nettype wire

// File: tb/tb_updown_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_ctrl
// Brief    : Directed segment-table bench for updown_ctrl (D=4, delay 10, period 3).
// Revision : 1.0 - initial release
// ============================================================================

module tb_updown_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_up;
  logic btn_down;
  logic enable;
  logic direction;

  always #5 clk = ~clk;

  updown_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .enable   (enable),
    .direction(direction)
  );

`ifdef UPDOWN_CTRL_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  // One record: hold the inputs for len cycles; mask bit j = pulse after step j.
  typedef struct {
    logic        up;
    logic        dn;
    int          len;
    logic [63:0] mask;
    logic        dir;
  } seg_t;

  seg_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_dir;

  function automatic logic [63:0] b(input int n);
    return 64'd1 << n;
  endfunction

  function automatic seg_t mk(input logic up, input logic dn, input int len,
                              input logic [63:0] mask, input logic dir);
    seg_t s;
    s.up   = up;
    s.dn   = dn;
    s.len  = len;
    s.mask = mask;
    s.dir  = dir;
    return s;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic run_seg(input seg_t s, input string tag);
    logic exp_en;
    btn_up   = s.up;
    btn_down = s.dn;
    for (int j = 0; j < s.len; j++) begin
      @(posedge clk);
      #1;
      exp_en = s.mask[j];
      if (exp_en) exp_dir = s.dir;
      check($sformatf("%s.enable@%0d", tag, j), enable, exp_en);
      check($sformatf("%s.direction@%0d", tag, j), direction, exp_dir);
    end
  endtask

  initial begin
    logic [63:0] m6;

    rst      = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    exp_dir  = 1'b1;

    #1 rst = 1'b1;
    #1;
    check("reset.enable", enable, 1'b0);
    check("reset.direction", direction, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Scenario 1: clean up press and release
    tbl.push_back(mk(1'b1, 1'b0, 20, b(7) | (AR ? b(17) : 64'd0), 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 12, AR ? (b(0) | b(3) | b(6)) : 64'd0, 1'b1));
    // Scenario 2: six 1-cycle glitch pairs on down, then a stable press
    for (int k = 0; k < 6; k++) begin
      tbl.push_back(mk(1'b0, 1'b1, 1, 64'd0, 1'b0));
      tbl.push_back(mk(1'b0, 1'b0, 1, 64'd0, 1'b0));
    end
    tbl.push_back(mk(1'b0, 1'b1, 14, b(7), 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 12, AR ? (b(3) | b(6)) : 64'd0, 1'b0));
    // Scenario 3: simultaneous press locks, then a fresh up press
    tbl.push_back(mk(1'b1, 1'b1, 30, 64'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 12, 64'd0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 12, b(7), 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 12, AR ? b(5) : 64'd0, 1'b1));
    // Scenario 4: up held, down joins; lock holds while down alone remains
    tbl.push_back(mk(1'b1, 1'b0, 15, b(7), 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 20, AR ? (b(2) | b(5)) : 64'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 12, 64'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 12, 64'd0, 1'b1));
    // Down press so the reset scenarios see direction leave 0
    tbl.push_back(mk(1'b0, 1'b1, 12, b(7), 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 12, AR ? b(5) : 64'd0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_seg(tbl[i], $sformatf("tbl%0d", i));
    end

    // Scenario 5: asynchronous reset mid-debounce with up held
    btn_up   = 1'b1;
    btn_down = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("s5.pre.enable@%0d", j), enable, 1'b0);
      check($sformatf("s5.pre.direction@%0d", j), direction, exp_dir);
    end
    #1 rst = 1'b1;
    #1;
    exp_dir = 1'b1;
    check("s5.async.enable", enable, 1'b0);
    check("s5.async.direction", direction, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("s5.held.enable", enable, 1'b0);
    rst = 1'b0;
    run_seg(mk(1'b1, 1'b0, 12, b(7), 1'b1), "s5.press");
    run_seg(mk(1'b0, 1'b0, 12, AR ? b(5) : 64'd0, 1'b1), "s5.release");

    // Reset landing while enable is high clears it without a clock
    run_seg(mk(1'b0, 1'b1, 8, b(7), 1'b0), "rstpulse.press");
    rst = 1'b1;
    #1;
    exp_dir = 1'b1;
    check("rstpulse.enable", enable, 1'b0);
    check("rstpulse.direction", direction, 1'b1);
    btn_down = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Scenario 6: long up hold (repeat train only with auto-repeat)
    m6 = b(7);
    if (AR) begin
      for (int k = 17; k < 40; k += 3) m6 = m6 | b(k);
    end
    run_seg(mk(1'b1, 1'b0, 40, m6, 1'b1), "s6.hold");
    run_seg(mk(1'b0, 1'b0, 12, AR ? (b(1) | b(4)) : 64'd0, 1'b1), "s6.release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
